// File: rtl/mem_responder.sv
// mem_responder: word-addressed synchronous memory with a four-phase
// request/acknowledge handshake and a fixed number of wait states.
//
// Ports:
//   i_clk        system clock, rising-edge active
//   i_rst_n      synchronous active-low reset
//   i_address    word address (from the datapath MAR)
//   i_read       read request strobe
//   i_write      write request strobe
//   i_din        write data (from the datapath MDR)
//   o_mdatain    registered read data, held between reads
//   o_mem_ready  access complete, high for the whole acknowledge phase
//   o_req_err    sticky flag: read and write requested together
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_mdatain,
  output logic              o_mem_ready,
  output logic              o_req_err
);

  localparam int       DEPTH   = 1 << ADDR_W;
  localparam logic [2:0] LP_WAIT = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t              r_state;
  logic [2:0]          r_cnt;
  logic                r_is_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_din;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ready;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic w_strobe;
  logic w_accept;
  logic w_access;
  logic w_mem_we;

  // Only the strobe of the accepted direction matters once a request is
  // in flight; the opposite strobe is ignored until back in IDLE.
  assign w_strobe = r_is_wr ? i_write : i_read;
  assign w_accept = (r_state == S_IDLE) && (i_read ^ i_write);
  assign w_access = (r_state == S_WAIT) && w_strobe && (r_cnt == 3'd0);
  // Reset has priority: a write due on a reset edge is suppressed.
  assign w_mem_we = i_rst_n && w_access && r_is_wr;

  // Storage array: never reset, contents survive reset.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[r_addr] <= r_din;
  end

  // Request address/data capture; pure data, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_addr <= i_address;
      r_din  <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_is_wr <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_read && i_write) begin
            r_err <= 1'b1;
          end else if (w_accept) begin
            r_is_wr <= i_write;
            r_cnt   <= LP_WAIT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!w_strobe) begin
            // Requester withdrew: abort without touching memory or read data.
            r_state <= S_IDLE;
          end else if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            if (!r_is_wr) r_rdata <= r_mem[r_addr];
            r_ready <= 1'b1;
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          if (!w_strobe) begin
            r_ready <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mdatain   = r_rdata;
  assign o_mem_ready = r_ready;
  assign o_req_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven plus scoreboard bench for mem_responder.
// Two instances: one with two wait states, one with zero wait states.
module tb_mem_responder;

  logic        clk;
  logic        rst_n;

  logic [8:0]  addr2, addr0;
  logic        rd2, wr2, rd0, wr0;
  logic [31:0] din2, din0;
  logic [31:0] q2, q0;
  logic        rdy2, rdy0, err2, err0;

  mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_address(addr2), .i_read(rd2),
    .i_write(wr2), .i_din(din2), .o_mdatain(q2), .o_mem_ready(rdy2),
    .o_req_err(err2)
  );

  mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_address(addr0), .i_read(rd0),
    .i_write(wr0), .i_din(din0), .o_mdatain(q0), .o_mem_ready(rdy0),
    .o_req_err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [8:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] exp_q [$];
  logic [31:0] last_q [2];
  int          vec_cnt = 0;
  int          err_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // sel 0 -> two-wait instance, sel 1 -> zero-wait instance
  task automatic drive(input bit sel, input logic r, input logic w,
                       input logic [8:0] a, input logic [31:0] d);
    if (sel) begin rd0 = r; wr0 = w; addr0 = a; din0 = d; end
    else     begin rd2 = r; wr2 = w; addr2 = a; din2 = d; end
  endtask

  function automatic logic get_rdy(input bit sel);
    return sel ? rdy0 : rdy2;
  endfunction

  function automatic logic [31:0] get_q(input bit sel);
    return sel ? q0 : q2;
  endfunction

  function automatic logic get_err(input bit sel);
    return sel ? err0 : err2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Complete one handshake. n counts edges from the one that samples the
  // request (n=1), so ready must first be seen at n = WAIT_CYCLES + 2.
  task automatic access(input bit sel, input bit wr, input logic [8:0] a,
                        input logic [31:0] d, input logic [31:0] exp, input int hold);
    int          n;
    bit          got;
    logic [31:0] e;
    n   = 0;
    got = 0;
    if (!wr) exp_q.push_back(exp);
    drive(sel, !wr, wr, a, d);
    while (!got && n < 30) begin
      step();
      n++;
      if (get_rdy(sel)) got = 1;
    end
    chk(wr ? "write latency" : "read latency", 32'(n), sel ? 32'd2 : 32'd4);
    if (!wr) begin
      e = exp_q.pop_front();
      chk("read data", get_q(sel), e);
      last_q[sel] = e;
    end else begin
      chk("write keeps mdatain", get_q(sel), last_q[sel]);
    end
    for (int i = 0; i < hold; i++) begin
      step();
      chk("ready held in ack", {31'd0, get_rdy(sel)}, 32'd1);
    end
    drive(sel, 1'b0, 1'b0, a, d);
    step();
    chk("ready cleared", {31'd0, get_rdy(sel)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0] = '{1'b1, 9'h012, 32'h4A920000, 32'h0, 0};
    tbl[1] = '{1'b0, 9'h012, 32'h0, 32'h4A920000, 0};
    tbl[2] = '{1'b1, 9'h020, 32'h00000026, 32'h0, 0};
    tbl[3] = '{1'b1, 9'h1FF, 32'hDEADBEEF, 32'h0, 0};
    tbl[4] = '{1'b0, 9'h1FF, 32'h0, 32'hDEADBEEF, 0};
    tbl[5] = '{1'b0, 9'h020, 32'h0, 32'h00000026, 1};
    tbl[6] = '{1'b1, 9'h030, 32'h12345678, 32'h0, 0};
    tbl[7] = '{1'b0, 9'h030, 32'h0, 32'h12345678, 0};
    tbl[8] = '{1'b1, 9'h012, 32'h00000000, 32'h0, 0};
    tbl[9] = '{1'b0, 9'h012, 32'h0, 32'h00000000, 0};

    rst_n = 1'b0;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    last_q[0] = '0;
    last_q[1] = '0;
    repeat (3) step();
    chk("reset ready", {31'd0, rdy2}, 32'd0);
    chk("reset err", {31'd0, err2}, 32'd0);
    chk("reset mdatain", q2, 32'd0);
    chk("reset ready z", {31'd0, rdy0}, 32'd0);
    chk("reset err z", {31'd0, err0}, 32'd0);
    chk("reset mdatain z", q0, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++)
      access(0, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].exp, tbl[i].hold);

    // Handshake hold: read stays high four extra cycles in ACK.
    access(0, 1'b0, 9'h020, 32'h0, 32'h00000026, 4);

    // Abort: write withdrawn after one WAIT cycle.
    drive(0, 1'b0, 1'b1, 9'h020, 32'hFFFFFFFF);
    step();
    step();
    drive(0, 1'b0, 1'b0, 9'h020, 32'hFFFFFFFF);
    step();
    chk("abort ready", {31'd0, rdy2}, 32'd0);
    step();
    chk("abort ready later", {31'd0, rdy2}, 32'd0);
    chk("abort keeps mdatain", q2, last_q[0]);
    access(0, 1'b0, 9'h020, 32'h0, 32'h00000026, 0);

    // Address, data and opposite strobe changes after acceptance are ignored.
    drive(0, 1'b0, 1'b1, 9'h040, 32'hA5A5A5A5);
    step();
    n = 1;
    drive(0, 1'b1, 1'b1, 9'h041, 32'h00000000);
    while (!rdy2 && n < 30) begin
      step();
      n++;
    end
    chk("late change latency", 32'(n), 32'd4);
    drive(0, 1'b0, 1'b0, 9'h041, 32'h0);
    step();
    chk("late change ready cleared", {31'd0, rdy2}, 32'd0);
    access(0, 1'b0, 9'h040, 32'h0, 32'hA5A5A5A5, 0);

    // Conflict: both strobes together are ignored and flagged.
    drive(0, 1'b1, 1'b1, 9'h012, 32'h0);
    step();
    chk("conflict err", {31'd0, err2}, 32'd1);
    chk("conflict ready", {31'd0, rdy2}, 32'd0);
    step();
    chk("conflict ready later", {31'd0, rdy2}, 32'd0);
    drive(0, 1'b0, 1'b0, 9'h012, 32'h0);
    step();
    chk("conflict no ack", {31'd0, rdy2}, 32'd0);
    access(0, 1'b0, 9'h1FF, 32'h0, 32'hDEADBEEF, 0);
    chk("err sticky", {31'd0, err2}, 32'd1);

    // Reset during WAIT of a write to 0x030.
    drive(0, 1'b0, 1'b1, 9'h030, 32'hCAFEF00D);
    step();
    step();
    rst_n = 1'b0;
    step();
    step();
    chk("mid reset ready", {31'd0, rdy2}, 32'd0);
    chk("mid reset err", {31'd0, err2}, 32'd0);
    chk("mid reset mdatain", q2, 32'd0);
    drive(0, 1'b0, 1'b0, 9'h030, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    last_q[0] = '0;
    last_q[1] = '0;
    access(0, 1'b0, 9'h030, 32'h0, 32'h12345678, 0);

    // Zero wait states: preload then read back with one-edge latency.
    access(1, 1'b1, 9'h005, 32'h00000022, 32'h0, 0);
    access(1, 1'b0, 9'h005, 32'h0, 32'h00000022, 0);
    chk("zero wait err", {31'd0, get_err(1)}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
